// File: rtl/data_mem_if.sv
// CPU data-port and data-RAM signal bundle for the data memory controller.
// master: the CPU/RAM environment side; slave: the controller itself.
interface data_mem_if #(
    parameter int unsigned ADDR_W = 10
) ();
    // CPU side
    logic              cpu_req;
    logic [2:0]        cpu_mem_fn;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_write_data;
    logic [31:0]       cpu_read_data;
    logic              cpu_stall;
    logic              cpu_done;
    logic              cpu_misalign;
    // RAM side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    modport master (
        output cpu_req, cpu_mem_fn, cpu_addr, cpu_write_data,
        input  cpu_read_data, cpu_stall, cpu_done, cpu_misalign,
        input  mem_en, mem_we, mem_addr, mem_write_data,
        output mem_read_data
    );

    modport slave (
        input  cpu_req, cpu_mem_fn, cpu_addr, cpu_write_data,
        output cpu_read_data, cpu_stall, cpu_done, cpu_misalign,
        output mem_en, mem_we, mem_addr, mem_write_data,
        input  mem_read_data
    );
endinterface

// File: rtl/data_mem_controller.sv
// Data memory controller: sequences CPU byte/half/word loads and stores onto a
// single-port, word-addressed, synchronous-read RAM. Sub-word stores are done
// as read-modify-write; loads are lane-extracted and sign/zero extended.
module data_mem_controller #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);

    // Memory function encodings
    localparam logic [2:0] MemLb  = 3'd0;
    localparam logic [2:0] MemLh  = 3'd1;
    localparam logic [2:0] MemLw  = 3'd2;
    localparam logic [2:0] MemSb  = 3'd3;
    localparam logic [2:0] MemLbu = 3'd4;
    localparam logic [2:0] MemLhu = 3'd5;
    localparam logic [2:0] MemSh  = 3'd6;
    localparam logic [2:0] MemSw  = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StLdWait,
        StRmwRd,
        StRmwWr,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          fn_q, fn_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         merged_q, merged_d;
    logic                misalign_q, misalign_d;

    logic                accept;
    logic [ADDR_W-1:0]   cpu_waddr;
    logic                unused_addr_hi;

    function automatic logic is_load(input logic [2:0] fn);
        return (fn == MemLb) || (fn == MemLbu) || (fn == MemLh) ||
               (fn == MemLhu) || (fn == MemLw);
    endfunction

    function automatic logic is_store(input logic [2:0] fn);
        return (fn == MemSb) || (fn == MemSh) || (fn == MemSw);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] fn, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (fn)
            MemLw, MemSw:         mis = (off != 2'b00);
            MemLh, MemLhu, MemSh: mis = off[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Pick the addressed lane out of the RAM word and extend it to 32 bits
    function automatic logic [31:0] load_extract(input logic [2:0]  fn,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        lane_b = word[{off, 3'b000} +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (fn)
            MemLb:   res = {{24{lane_b[7]}}, lane_b};
            MemLbu:  res = {24'h0, lane_b};
            MemLh:   res = {{16{lane_h[15]}}, lane_h};
            MemLhu:  res = {16'h0, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Insert right-aligned store data into the old word at the addressed lane
    function automatic logic [31:0] store_merge(input logic [2:0]  fn,
                                                input logic [1:0]  off,
                                                input logic [31:0] old_word,
                                                input logic [31:0] data);
        logic [31:0] res;
        res = old_word;
        case (fn)
            MemSb:   res[{off, 3'b000} +: 8]     = data[7:0];
            MemSh:   res[{off[1], 4'b0000} +: 16] = data[15:0];
            default: res = data;
        endcase
        return res;
    endfunction

    assign cpu_waddr      = bus.cpu_addr[ADDR_W+1:2];
    // Upper address bits wrap within the RAM
    assign unused_addr_hi = ^bus.cpu_addr[31:ADDR_W+2];

    // rst_n gates the accept so no RAM strobe escapes while reset is asserted
    assign accept = (state_q == StIdle) && bus.cpu_req && rst_n &&
                    (is_load(bus.cpu_mem_fn) || is_store(bus.cpu_mem_fn));

    // Next-state, latched request fields and RAM strobes
    always_comb begin
        state_d            = state_q;
        fn_d               = fn_q;
        off_d              = off_q;
        waddr_d            = waddr_q;
        wdata_d            = wdata_q;
        rdata_d            = rdata_q;
        merged_d           = merged_q;
        misalign_d         = misalign_q;
        bus.mem_en         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = waddr_q;
        bus.mem_write_data = '0;
        bus.cpu_stall      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    fn_d          = bus.cpu_mem_fn;
                    off_d         = bus.cpu_addr[1:0];
                    waddr_d       = cpu_waddr;
                    wdata_d       = bus.cpu_write_data;
                    misalign_d    = 1'b0;
                    bus.cpu_stall = 1'b1;
                    bus.mem_addr  = cpu_waddr;
                    if (is_misaligned(bus.cpu_mem_fn, bus.cpu_addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = StDone;
                    end else if (is_load(bus.cpu_mem_fn)) begin
                        bus.mem_en = 1'b1;
                        state_d    = StLdWait;
                    end else if (bus.cpu_mem_fn == MemSw) begin
                        bus.mem_en         = 1'b1;
                        bus.mem_we         = 1'b1;
                        bus.mem_write_data = bus.cpu_write_data;
                        state_d            = StDone;
                    end else begin
                        bus.mem_en = 1'b1;
                        state_d    = StRmwRd;
                    end
                end
            end
            StLdWait: begin
                bus.cpu_stall = 1'b1;
                rdata_d       = load_extract(fn_q, off_q, bus.mem_read_data);
                state_d       = StDone;
            end
            StRmwRd: begin
                bus.cpu_stall = 1'b1;
                merged_d      = store_merge(fn_q, off_q, bus.mem_read_data, wdata_q);
                state_d       = StRmwWr;
            end
            StRmwWr: begin
                bus.cpu_stall      = 1'b1;
                bus.mem_en         = 1'b1;
                bus.mem_we         = 1'b1;
                bus.mem_write_data = merged_q;
                state_d            = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fn_q       <= '0;
            off_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            merged_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fn_q       <= fn_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            merged_q   <= merged_d;
            misalign_q <= misalign_d;
        end
    end

    // CPU-facing completion outputs
    always_comb begin
        bus.cpu_done      = (state_q == StDone);
        bus.cpu_misalign  = (state_q == StDone) && misalign_q;
        bus.cpu_read_data = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: behavioural RAM, shadow-memory
// reference model and a scoreboard of expected completions.
module tb_data_mem_controller;

    localparam logic [2:0] FN_LB  = 3'd0;
    localparam logic [2:0] FN_LH  = 3'd1;
    localparam logic [2:0] FN_LW  = 3'd2;
    localparam logic [2:0] FN_SB  = 3'd3;
    localparam logic [2:0] FN_LBU = 3'd4;
    localparam logic [2:0] FN_LHU = 3'd5;
    localparam logic [2:0] FN_SH  = 3'd6;
    localparam logic [2:0] FN_SW  = 3'd7;

    typedef struct {
        logic [31:0] rdata;
        logic        misalign;
        int          lat;
        int          en;
        int          we;
    } exp_t;

    logic clk;
    logic rst_n;

    data_mem_if #(.ADDR_W(10)) bus ();

    data_mem_controller #(.ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] ram    [0:1023];
    logic [31:0] shadow [0:1023];
    logic [31:0] mem_rd;
    logic [31:0] last_load;
    exp_t        sb_q[$];
    int          en_cnt;
    int          we_cnt;
    int          we_no_en;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_write_data;
            else            mem_rd <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_read_data = mem_rd;

    // RAM strobe monitor
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.mem_en) en_cnt <= en_cnt + 1;
            if (bus.mem_we) we_cnt <= we_cnt + 1;
            if (bus.mem_we && !bus.mem_en) we_no_en <= we_no_en + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: compute expected completion and update the shadow memory
    task automatic predict(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        logic [1:0]  off;
        logic [9:0]  wa;
        logic [31:0] w;
        logic [31:0] sh;
        logic        mis;
        off = addr[1:0];
        wa  = addr[11:2];
        w   = shadow[wa];
        if (fn == FN_LW || fn == FN_SW)                   mis = (off != 2'd0);
        else if (fn == FN_LH || fn == FN_LHU || fn == FN_SH) mis = (off == 2'd1 || off == 2'd3);
        else                                              mis = 1'b0;
        e.misalign = mis;
        e.lat = 1; e.en = 0; e.we = 0;
        if (!mis) begin
            sh = w >> (8 * off);
            case (fn)
                FN_LB:  begin last_load = {{24{sh[7]}}, sh[7:0]};  e.lat = 2; e.en = 1; end
                FN_LBU: begin last_load = {24'h0, sh[7:0]};        e.lat = 2; e.en = 1; end
                FN_LH:  begin last_load = {{16{sh[15]}}, sh[15:0]}; e.lat = 2; e.en = 1; end
                FN_LHU: begin last_load = {16'h0, sh[15:0]};       e.lat = 2; e.en = 1; end
                FN_LW:  begin last_load = w;                       e.lat = 2; e.en = 1; end
                FN_SW:  begin shadow[wa] = wd; e.lat = 1; e.en = 1; e.we = 1; end
                FN_SB: begin
                    case (off)
                        2'd0: w[7:0]   = wd[7:0];
                        2'd1: w[15:8]  = wd[7:0];
                        2'd2: w[23:16] = wd[7:0];
                        default: w[31:24] = wd[7:0];
                    endcase
                    shadow[wa] = w; e.lat = 3; e.en = 2; e.we = 1;
                end
                default: begin
                    if (off[1]) w[31:16] = wd[15:0];
                    else        w[15:0]  = wd[15:0];
                    shadow[wa] = w; e.lat = 3; e.en = 2; e.we = 1;
                end
            endcase
        end
        e.rdata = last_load;
        sb_q.push_back(e);
    endtask

    // Issue one request from an IDLE cycle (called just after a negedge), wait for done
    task automatic do_req(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, input bit chg);
        exp_t e;
        int   en0;
        int   we0;
        int   n;
        bit   done;
        bus.cpu_req        = 1'b1;
        bus.cpu_mem_fn     = fn;
        bus.cpu_addr       = addr;
        bus.cpu_write_data = wd;
        predict(fn, addr, wd);
        en0 = en_cnt;
        we0 = we_cnt;
        #1;
        check_eq("accept_stall", {31'h0, bus.cpu_stall}, 32'd1);
        n    = 0;
        done = 1'b0;
        while (n < 10 && !done) begin
            @(negedge clk);
            n++;
            if (bus.cpu_done) begin
                done = 1'b1;
            end else begin
                check_eq("busy_stall", {31'h0, bus.cpu_stall}, 32'd1);
                if (chg) begin
                    bus.cpu_mem_fn     = 3'($urandom);
                    bus.cpu_addr       = $urandom;
                    bus.cpu_write_data = $urandom;
                end
            end
        end
        e = sb_q.pop_front();
        if (!done) begin
            check_eq("done_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", n, e.lat);
            check_eq("read_data", bus.cpu_read_data, e.rdata);
            check_eq("misalign", {31'h0, bus.cpu_misalign}, {31'h0, e.misalign});
            check_eq("done_stall", {31'h0, bus.cpu_stall}, 32'd0);
            check_eq("mem_en_cycles", en_cnt - en0, e.en);
            check_eq("mem_we_cycles", we_cnt - we0, e.we);
        end
        if (!hold) bus.cpu_req = 1'b0;
        @(negedge clk);
        check_eq("done_pulse", {31'h0, bus.cpu_done}, 32'd0);
        if (!hold) check_eq("idle_stall", {31'h0, bus.cpu_stall}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"}, {31'h0, bus.cpu_stall}, 32'd0);
        check_eq({tag, "_done"}, {31'h0, bus.cpu_done}, 32'd0);
        check_eq({tag, "_misalign"}, {31'h0, bus.cpu_misalign}, 32'd0);
        check_eq({tag, "_read_data"}, bus.cpu_read_data, 32'd0);
        check_eq({tag, "_mem_en"}, {31'h0, bus.mem_en}, 32'd0);
        check_eq({tag, "_mem_we"}, {31'h0, bus.mem_we}, 32'd0);
        check_eq({tag, "_mem_addr"}, {22'h0, bus.mem_addr}, 32'd0);
        check_eq({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
    endtask

    initial begin
        logic [2:0]  fn;
        logic [31:0] a;
        checks    = 0;
        failures  = 0;
        en_cnt    = 0;
        we_cnt    = 0;
        we_no_en  = 0;
        last_load = 32'h0;
        mem_rd    = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = $urandom;
            shadow[i] = ram[i];
        end
        ram[0] = 32'h8081_7F02; shadow[0] = 32'h8081_7F02;
        ram[1] = 32'h1122_3344; shadow[1] = 32'h1122_3344;

        // Reset with a live request on the bus: nothing may leak out
        rst_n              = 1'b0;
        bus.cpu_req        = 1'b1;
        bus.cpu_mem_fn     = FN_SW;
        bus.cpu_addr       = 32'h8;
        bus.cpu_write_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        bus.cpu_req = 1'b0;
        rst_n       = 1'b1;
        @(negedge clk);

        // Sub-word loads from RAM[0]
        do_req(FN_LB,  32'h3, 32'h0, 1'b0, 1'b0);
        check_eq("lb_value", bus.cpu_read_data, 32'hFFFF_FF80);
        do_req(FN_LBU, 32'h3, 32'h0, 1'b0, 1'b0);
        check_eq("lbu_value", bus.cpu_read_data, 32'h0000_0080);
        do_req(FN_LH,  32'h2, 32'h0, 1'b0, 1'b0);
        check_eq("lh_value", bus.cpu_read_data, 32'hFFFF_8081);
        do_req(FN_LHU, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("lhu_value", bus.cpu_read_data, 32'h0000_7F02);

        // Reset while the RMW read is outstanding: write abandoned
        bus.cpu_req        = 1'b1;
        bus.cpu_mem_fn     = FN_SB;
        bus.cpu_addr       = 32'h4;
        bus.cpu_write_data = 32'h55;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bus.cpu_req = 1'b0;
        we_no_en    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_load = 32'h0;
        @(negedge clk);
        check_eq("rmw_abandoned", ram[1], 32'h1122_3344);

        // Read-modify-write stores into RAM[1]
        do_req(FN_SB, 32'h6, 32'hAB, 1'b0, 1'b0);
        check_eq("sb_ram", ram[1], 32'h11AB_3344);
        do_req(FN_SH, 32'h4, 32'hBEEF, 1'b0, 1'b0);
        check_eq("sh_ram", ram[1], 32'h11AB_BEEF);

        // Word store then load back
        do_req(FN_SW, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("sw_ram", ram[2], 32'hDEAD_BEEF);
        do_req(FN_LW, 32'h8, 32'h0, 1'b0, 1'b0);
        check_eq("lw_value", bus.cpu_read_data, 32'hDEAD_BEEF);

        // Misaligned accesses: no RAM traffic, read data kept
        do_req(FN_LW, 32'h2, 32'h0, 1'b0, 1'b0);
        do_req(FN_SH, 32'h1, 32'h1234, 1'b0, 1'b0);
        check_eq("misalign_keep", bus.cpu_read_data, 32'hDEAD_BEEF);

        // Address wrap above the RAM range
        do_req(FN_LW, 32'hFFFF_F008, 32'h0, 1'b0, 1'b0);

        // Back-to-back random traffic, req held high, inputs scrambled mid-op
        for (int i = 0; i < 40; i++) begin
            fn = 3'($urandom);
            a  = {26'h0, 6'($urandom)};
            do_req(fn, a, $urandom, (i != 39), 1'b1);
        end

        for (int i = 0; i < 16; i++) check_eq("ram_final", ram[i], shadow[i]);
        check_eq("we_without_en", we_no_en, 32'd0);
        check_eq("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
